// File: rtl/imem_pipe.sv
// Word-organised instruction RAM with a byte-enabled program port and an
// elastic, flushable fetch port of LAT stages (valid/ready on both sides).
module imem_pipe #(
  parameter int          ADDR_W = 5,
  parameter int          LAT    = 1,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_be,
  input  logic [31:0]       wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  input  logic              flush
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       off;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic              advance;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic [31:0]       rd_merged;
  logic [31:0]       stage1_data;

  logic              valid_reg [1:LAT];
  logic [31:0]       data_reg  [1:LAT];
  logic              err_reg   [1:LAT];

  // Wrapping subtraction folds "below BASE" into the out-of-range test.
  assign off          = req_addr - BASE;
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = ({1'b0, off} >= SPAN);
  assign req_err      = misaligned || out_of_range;
  assign rd_idx       = off[ADDR_W+1:2];

  assign advance   = !valid_reg[LAT] || rsp_ready;
  assign req_ready = advance && !flush;
  assign accept    = req_valid && req_ready;

  assign rd_word = mem[rd_idx];

  // Write-first forwarding: a same-cycle write to the fetched word is merged per byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign rd_merged[8*gi +: 8] = (wr_en && wr_be[gi] && (wr_addr == rd_idx))
                                  ? wr_data[8*gi +: 8] : rd_word[8*gi +: 8];
  end

  assign stage1_data = (accept && !req_err) ? rd_merged : 32'h0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Flush only drops valids; data/err hold so the outputs never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LAT; k++) begin
        valid_reg[k] <= 1'b0;
        data_reg[k]  <= 32'h0;
        err_reg[k]   <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 1; k <= LAT; k++) valid_reg[k] <= 1'b0;
    end else if (advance) begin
      valid_reg[1] <= accept;
      data_reg[1]  <= stage1_data;
      err_reg[1]   <= accept && req_err;
      for (int k = 2; k <= LAT; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        data_reg[k]  <= data_reg[k-1];
        err_reg[k]   <= err_reg[k-1];
      end
    end
  end

  assign rsp_valid = valid_reg[LAT];
  assign rsp_data  = data_reg[LAT];
  assign rsp_err   = err_reg[LAT];

endmodule

// File: tb/tb_imem_pipe.sv
// Drives two imem_pipe instances (LAT=1/BASE=0 and LAT=3/BASE=0x1000) and
// checks them against an in-order scoreboard with a reference memory.
module tb_imem_pipe;

  logic        clk;
  logic        rst_n;
  logic        wr_en     [2];
  logic [4:0]  wr_addr   [2];
  logic [3:0]  wr_be     [2];
  logic [31:0] wr_data   [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        flush     [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference: memory image plus FIFO of expected responses; an entry becomes
  // visible once LAT pipeline advances have happened since it was accepted.
  logic [31:0] model_mem [2][32];
  logic [31:0] fd [2][8];
  logic        fe [2][8];
  int          fs [2][8];
  int          head [2];
  int          cnt [2];
  int          adv_cnt [2];
  int          dut_taken [2];
  logic        last_acc [2];

  imem_pipe #(.ADDR_W(5), .LAT(1), .BASE(32'h0000_0000)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_be(wr_be[0]), .wr_data(wr_data[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .flush(flush[0])
  );

  imem_pipe #(.ADDR_W(5), .LAT(3), .BASE(32'h0000_1000)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_be(wr_be[1]), .wr_data(wr_data[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .flush(flush[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      wr_en[i] = 1'b0; wr_addr[i] = '0; wr_be[i] = '0; wr_data[i] = '0;
      req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b1; flush[i] = 1'b0;
    end
  endtask

  // Called at a falling edge with inputs set; checks, updates the model, and
  // returns at the next falling edge.
  task automatic cycle();
    logic        ev, er, acc, adv, qe;
    logic [31:0] qd, off;
    int          slot;
    #1;
    for (int i = 0; i < 2; i++) begin
      ev = (cnt[i] > 0) && ((adv_cnt[i] - fs[i][head[i]]) >= lat_of(i));
      er = (!ev || rsp_ready[i]) && !flush[i];
      check("req_ready", 32'(req_ready[i]), 32'(er));
      check("rsp_valid", 32'(rsp_valid[i]), 32'(ev));
      if (ev) begin
        check("rsp_data", rsp_data[i], fd[i][head[i]]);
        check("rsp_err", 32'(rsp_err[i]), 32'(fe[i][head[i]]));
      end
      if (rsp_valid[i] && rsp_ready[i]) dut_taken[i]++;
      if (wr_en[i]) begin
        for (int b = 0; b < 4; b++)
          if (wr_be[i][b]) model_mem[i][wr_addr[i]][8*b +: 8] = wr_data[i][8*b +: 8];
      end
      acc = req_valid[i] && er;
      last_acc[i] = acc;
      adv = !ev || rsp_ready[i];
      if (ev && rsp_ready[i]) begin
        $display("inst%0d rsp data=%h err=%0d", i, fd[i][head[i]], fe[i][head[i]]);
        head[i] = (head[i] + 1) % 8;
        cnt[i]--;
      end
      if (flush[i]) begin
        cnt[i] = 0;
      end else if (adv) begin
        adv_cnt[i]++;
        if (acc) begin
          off  = req_addr[i] - base_of(i);
          qe   = (req_addr[i][1:0] != 2'b00) || (off >= 32'd128);
          qd   = qe ? 32'h0 : model_mem[i][off[6:2]];
          slot = (head[i] + cnt[i]) % 8;
          fd[i][slot] = qd;
          fe[i][slot] = qe;
          fs[i][slot] = adv_cnt[i] - 1;
          cnt[i]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input int i, input logic [31:0] a);
    idle();
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    cycle();
  endtask

  initial begin
    int k, t0;
    logic [31:0] a, b;
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      head[i] = 0; cnt[i] = 0; adv_cnt[i] = 0; dut_taken[i] = 0; last_acc[i] = 1'b0;
    end
    @(negedge clk);
    // Fill both memories under reset; the program port ignores rst_n.
    for (int w = 0; w < 32; w++) begin
      for (int i = 0; i < 2; i++) begin
        wr_en[i] = 1'b1; wr_addr[i] = 5'(w); wr_be[i] = 4'hF; wr_data[i] = $urandom;
        model_mem[i][w] = wr_data[i];
      end
      @(negedge clk);
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      check("reset_valid", 32'(rsp_valid[i]), 32'd0);
      check("reset_data", rsp_data[i], 32'd0);
      check("reset_err", 32'(rsp_err[i]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(req_ready[0]), 32'd1);
    @(negedge clk);

    // Write then fetch
    idle();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_be[0] = 4'hF; wr_data[0] = 32'hDEADBEEF;
    cycle();
    fetch(0, 32'd12);
    check("tp1_valid", 32'(rsp_valid[0]), 32'd1);
    check("tp1_data", rsp_data[0], 32'hDEADBEEF);
    check("tp1_err", 32'(rsp_err[0]), 32'd0);

    // Byte merge with same-cycle collision
    idle();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_be[0] = 4'b0010; wr_data[0] = 32'h0000_5500;
    req_valid[0] = 1'b1; req_addr[0] = 32'd12;
    cycle();
    check("tp2_merge", rsp_data[0], 32'hDEAD55EF);
    fetch(0, 32'd12);
    check("tp2_later", rsp_data[0], 32'hDEAD55EF);

    // Errors
    fetch(0, 32'd13);
    check("tp3_mis_err", 32'(rsp_err[0]), 32'd1);
    check("tp3_mis_data", rsp_data[0], 32'd0);
    fetch(0, 32'd128);
    check("tp3_range_err", 32'(rsp_err[0]), 32'd1);
    fetch(1, 32'h0000_0FFC);
    fetch(1, 32'h0000_1000);
    idle(); cycle();
    check("tp3_below_base", 32'(rsp_err[1]), 32'd1);
    idle(); cycle();
    check("tp3_base_err", 32'(rsp_err[1]), 32'd0);
    check("tp3_base_data", rsp_data[1], model_mem[1][0]);
    idle(); cycle(); cycle();

    // Backpressure on the LAT=3 instance
    k  = 0;
    t0 = dut_taken[1];
    for (int c = 0; c < 16; c++) begin
      idle();
      req_valid[1] = (k < 5);
      req_addr[1]  = 32'h0000_1000 + 32'(4 * k);
      rsp_ready[1] = !(c >= 4 && c <= 6);
      cycle();
      if (last_acc[1]) k++;
    end
    check("tp4_count", 32'(dut_taken[1] - t0), 32'd5);

    // Flush with three fetches in flight
    t0 = dut_taken[1];
    for (int j = 0; j < 3; j++) fetch(1, 32'h0000_1000 + 32'(4 * j));
    idle();
    req_valid[1] = 1'b1; req_addr[1] = 32'h0000_1010; flush[1] = 1'b1; rsp_ready[1] = 1'b0;
    #1;
    check("tp5_ready_low", 32'(req_ready[1]), 32'd0);
    cycle();
    fetch(1, 32'h0000_1014);
    for (int j = 0; j < 5; j++) begin idle(); cycle(); end
    check("tp5_count", 32'(dut_taken[1] - t0), 32'd1);

    // Asynchronous reset with fetches pending
    fetch(1, 32'h0000_1008);
    fetch(1, 32'h0000_100C);
    fetch(0, 32'd8);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("tp6_valid", 32'(rsp_valid[i]), 32'd0);
      check("tp6_data", rsp_data[i], 32'd0);
      check("tp6_err", 32'(rsp_err[i]), 32'd0);
      cnt[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin idle(); cycle(); end
    fetch(0, 32'd12);
    check("tp6_mem_kept", rsp_data[0], 32'hDEAD55EF);
    fetch(1, 32'h0000_100C);
    for (int j = 0; j < 4; j++) begin idle(); cycle(); end

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        b = base_of(i);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
        flush[i]     = ($urandom_range(0, 19) == 0);
        req_valid[i] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0: begin
            a = b + 32'($urandom_range(0, 127));
            if (a[1:0] == 2'b00) a[0] = 1'b1;
          end
          1: a = b + 32'd128 + 32'(4 * $urandom_range(0, 50));
          2: a = b - 32'(4 * $urandom_range(1, 8));
          default: a = b + 32'(4 * $urandom_range(0, 31));
        endcase
        req_addr[i] = a;
        wr_en[i]    = ($urandom_range(0, 2) == 0);
        wr_be[i]    = 4'($urandom);
        wr_data[i]  = $urandom;
        wr_addr[i]  = ($urandom_range(0, 1) == 0) ? 5'((a - b) >> 2) : 5'($urandom);
      end
      cycle();
    end
    for (int j = 0; j < 6; j++) begin idle(); cycle(); end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
